// File: rtl/reg_window_sel.sv
// reg_window_sel: registered A/C/J register-address selector with a bounded, flagged window pointer.
module reg_window_sel #(
  parameter int AW       = 4,
  parameter int PX_W     = 4,
  parameter int PX_MAX   = 12,
  parameter int WIN_STEP = 4,
  parameter int LR_IDX   = 14,
  parameter int PC_IDX   = 15,
  parameter int SP_IDX   = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ir,
  input  logic [1:0]      ma,
  input  logic [2:0]      mc,
  input  logic [1:0]      mj,
  input  logic            win_push,
  input  logic            win_pop,
  input  logic            stall,
  input  logic            clr_flags,
  output logic [AW-1:0]   addr_a,
  output logic [AW-1:0]   addr_c,
  output logic [AW-1:0]   addr_j,
  output logic [PX_W-1:0] px,
  output logic            out_valid,
  output logic            win_ovf,
  output logic            win_unf
);
  localparam logic [AW-1:0]   PC = AW'(PC_IDX);
  localparam logic [AW-1:0]   LR = AW'(LR_IDX);
  localparam logic [AW-1:0]   SP = AW'(SP_IDX);
  localparam logic [PX_W-1:0] STEP = PX_W'(WIN_STEP);
  // one extra bit so px + step cannot wrap before the limit check
  localparam logic [PX_W:0]   STEP_X = (PX_W+1)'(WIN_STEP);
  localparam logic [PX_W:0]   MAX_X  = (PX_W+1)'(PX_MAX);
  logic [AW-1:0]   addr_a_q, addr_a_d, addr_c_q, addr_c_d, addr_j_q, addr_j_d;
  logic [PX_W-1:0] px_q, px_d;
  logic            valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [AW-1:0]   f_rs, f_rd, f_rm, f_win;
  logic            push_ev, pop_ev, push_ok, pop_ok;
  always_comb begin
    f_rs     = AW'(ir[19:16]);
    f_rd     = AW'(ir[15:12]);
    f_rm     = AW'(ir[3:0]);
    f_win    = f_rd + AW'(px_q);
    push_ev  = win_push & ~win_pop & ~stall;
    pop_ev   = win_pop & ~win_push & ~stall;
    push_ok  = ({1'b0, px_q} + STEP_X) <= MAX_X;
    pop_ok   = {1'b0, px_q} >= STEP_X;
    addr_a_d = stall ? addr_a_q : ma == 2'd0 ? f_rs : ma == 2'd1 ? f_win : ma == 2'd2 ? PC : addr_a_q;
    addr_c_d = stall ? addr_c_q : mc == 3'd0 ? f_win : mc == 3'd1 ? f_rs : mc == 3'd2 ? LR :
               mc == 3'd3 ? PC : mc == 3'd4 ? SP : addr_c_q;
    addr_j_d = stall ? addr_j_q : mj == 2'd0 ? f_rm : mj == 2'd1 ? SP : mj == 2'd2 ? f_rd : addr_j_q;
    px_d     = (push_ev && push_ok) ? px_q + STEP : (pop_ev && pop_ok) ? px_q - STEP : px_q;
    ovf_d    = (push_ev & ~push_ok) | (ovf_q & ~clr_flags);
    unf_d    = (pop_ev & ~pop_ok) | (unf_q & ~clr_flags);
    valid_d  = ~stall;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_a_q <= '0;
      addr_c_q <= '0;
      addr_j_q <= '0;
      px_q     <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      addr_a_q <= addr_a_d;
      addr_c_q <= addr_c_d;
      addr_j_q <= addr_j_d;
      px_q     <= px_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  assign addr_a    = addr_a_q;
  assign addr_c    = addr_c_q;
  assign addr_j    = addr_j_q;
  assign px        = px_q;
  assign out_valid = valid_q;
  assign win_ovf   = ovf_q;
  assign win_unf   = unf_q;
endmodule

// File: tb/tb_reg_window_sel.sv
// tb_reg_window_sel: table-driven cycle vectors plus a hand-written mid-operation reset sequence.
module tb_reg_window_sel;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] ir = '0;
  logic [1:0]  ma = 2'd3, mj = 2'd3;
  logic [2:0]  mc = 3'd5;
  logic        win_push = 1'b0, win_pop = 1'b0, stall = 1'b0, clr_flags = 1'b0;
  logic [3:0]  addr_a, addr_c, addr_j, px;
  logic        out_valid, win_ovf, win_unf;
  int          n_run = 0, n_fail = 0;
  typedef struct packed {
    logic        rst;
    logic [31:0] ir;
    logic [1:0]  ma;
    logic [2:0]  mc;
    logic [1:0]  mj;
    logic        push, pop, stl, clr;
    logic [3:0]  ea, ec, ej, epx;
    logic        ev, eo, eu;
  } vec_t;
  vec_t vecs[$];
  reg_window_sel dut (
    .clk(clk), .reset(reset), .ir(ir), .ma(ma), .mc(mc), .mj(mj),
    .win_push(win_push), .win_pop(win_pop), .stall(stall), .clr_flags(clr_flags),
    .addr_a(addr_a), .addr_c(addr_c), .addr_j(addr_j), .px(px),
    .out_valid(out_valid), .win_ovf(win_ovf), .win_unf(win_unf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " addr_a"}, addr_a, v.ea);
    chk({tag, " addr_c"}, addr_c, v.ec);
    chk({tag, " addr_j"}, addr_j, v.ej);
    chk({tag, " px"}, px, v.epx);
    chk({tag, " out_valid"}, out_valid, v.ev);
    chk({tag, " win_ovf"}, win_ovf, v.eo);
    chk({tag, " win_unf"}, win_unf, v.eu);
  endtask
  task automatic step(input logic r, input logic [31:0] i, input logic [1:0] a, input logic [2:0] c,
                      input logic [1:0] j, input logic pu, input logic po, input logic s, input logic cl);
    @(negedge clk);
    reset = r; ir = i; ma = a; mc = c; mj = j;
    win_push = pu; win_pop = po; stall = s; clr_flags = cl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    //            rst ir            ma    mc    mj    pu   po   st   cl   a     c     j     px    v    o    u
    vecs.push_back({1'b1, 32'h0,        2'd3, 3'd5, 2'd3, 1'b0,1'b0,1'b0,1'b0, 4'h0, 4'h0, 4'h0, 4'd0, 1'b0,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0003_0000,2'd0, 3'd5, 2'd3, 1'b0,1'b0,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd0, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b1,1'b0,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd4, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b1,1'b0,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd8, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b1,1'b0,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd12,1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b1,1'b0,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd12,1'b1,1'b1,1'b0});
    vecs.push_back({1'b0, 32'h0000_6000,2'd1, 3'd5, 2'd3, 1'b0,1'b0,1'b0,1'b0, 4'h2, 4'h0, 4'h0, 4'd12,1'b1,1'b1,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b0,1'b0,1'b0,1'b1, 4'h2, 4'h0, 4'h0, 4'd12,1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd2, 3'd5, 2'd3, 1'b0,1'b1,1'b0,1'b0, 4'hF, 4'h0, 4'h0, 4'd8, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b1, 32'hFFFF_FFFF,2'd0, 3'd0, 2'd0, 1'b1,1'b0,1'b1,1'b1, 4'h0, 4'h0, 4'h0, 4'd0, 1'b0,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0003_0000,2'd0, 3'd5, 2'd3, 1'b0,1'b0,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd0, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b0,1'b1,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd0, 1'b1,1'b0,1'b1});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b0,1'b0,1'b0,1'b1, 4'h3, 4'h0, 4'h0, 4'd0, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b0,1'b1,1'b0,1'b1, 4'h3, 4'h0, 4'h0, 4'd0, 1'b1,1'b0,1'b1});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b0,1'b0,1'b0,1'b1, 4'h3, 4'h0, 4'h0, 4'd0, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b1,1'b0,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd4, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b1,1'b1,1'b0,1'b0, 4'h3, 4'h0, 4'h0, 4'd4, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0000_1000,2'd3, 3'd0, 2'd3, 1'b1,1'b0,1'b0,1'b0, 4'h3, 4'h5, 4'h0, 4'd8, 1'b1,1'b0,1'b0});
    for (int k = 0; k < 3; k++)
      vecs.push_back({1'b0, 32'h0,    2'd3, 3'd2, 2'd1, 1'b1,1'b0,1'b1,1'b0, 4'h3, 4'h5, 4'h0, 4'd8, 1'b0,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd2, 2'd1, 1'b0,1'b0,1'b0,1'b0, 4'h3, 4'hE, 4'h7, 4'd8, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd2, 3'd5, 2'd3, 1'b0,1'b0,1'b0,1'b0, 4'hF, 4'hE, 4'h7, 4'd8, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'hFFFF_FFFF,2'd3, 3'd6, 2'd3, 1'b0,1'b0,1'b0,1'b0, 4'hF, 4'hE, 4'h7, 4'd8, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0000_000A,2'd3, 3'd4, 2'd0, 1'b0,1'b0,1'b0,1'b0, 4'hF, 4'h7, 4'hA, 4'd8, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0009_B000,2'd3, 3'd1, 2'd2, 1'b0,1'b0,1'b0,1'b0, 4'hF, 4'h9, 4'hB, 4'd8, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h1234_5678,2'd3, 3'd3, 2'd3, 1'b0,1'b0,1'b0,1'b0, 4'hF, 4'hF, 4'hB, 4'd8, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b0,1'b1,1'b0,1'b0, 4'hF, 4'hF, 4'hB, 4'd4, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0000_E000,2'd1, 3'd5, 2'd3, 1'b0,1'b1,1'b0,1'b0, 4'h2, 4'hF, 4'hB, 4'd0, 1'b1,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd3, 3'd5, 2'd3, 1'b0,1'b1,1'b0,1'b0, 4'h2, 4'hF, 4'hB, 4'd0, 1'b1,1'b0,1'b1});
    vecs.push_back({1'b0, 32'h0,        2'd0, 3'd0, 2'd0, 1'b0,1'b0,1'b1,1'b1, 4'h2, 4'hF, 4'hB, 4'd0, 1'b0,1'b0,1'b0});
    vecs.push_back({1'b0, 32'h0,        2'd0, 3'd0, 2'd0, 1'b0,1'b1,1'b1,1'b0, 4'h2, 4'hF, 4'hB, 4'd0, 1'b0,1'b0,1'b0});
    vecs.push_back({1'b0, 32'hABCD_EF01,2'd3, 3'd7, 2'd3, 1'b0,1'b0,1'b0,1'b0, 4'h2, 4'hF, 4'hB, 4'd0, 1'b1,1'b0,1'b0});
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ir, vecs[i].ma, vecs[i].mc, vecs[i].mj,
           vecs[i].push, vecs[i].pop, vecs[i].stl, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end
    // mid-operation reset with overflow flag and window pointer both non-zero
    step(1'b0, 32'h0000_0000, 2'd2, 3'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0000_0000, 2'd3, 3'd5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0000_0000, 2'd3, 3'd5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0000_0000, 2'd3, 3'd5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("seq_pre", {1'b0, 32'h0, 2'd0, 3'd0, 2'd0, 4'b0, 4'hF, 4'hF, 4'h7, 4'd12, 1'b1, 1'b1, 1'b0});
    step(1'b1, 32'h0000_0000, 2'd3, 3'd5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("seq_rst", {1'b0, 32'h0, 2'd0, 3'd0, 2'd0, 4'b0, 4'h0, 4'h0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0});
    step(1'b0, 32'h0005_C000, 2'd1, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("seq_post", {1'b0, 32'h0, 2'd0, 3'd0, 2'd0, 4'b0, 4'hC, 4'hC, 4'hC, 4'd0, 1'b1, 1'b0, 1'b0});
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
